// File: rtl/scan_target_router.sv
// Registered router from the scan controller to N_TGT scan-addressable targets,
// with unmapped/conflict error reporting. Define SCAN_ROUTER_TIMEOUT_EN to build the ready timeout.
module scan_target_router #(
  parameter int N_TGT   = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_ren,
  input  logic                    scan_wen,
  input  logic [ADDR_W-1:0]       scan_addr,
  input  logic [DATA_W-1:0]       scan_wdata,
  output logic [DATA_W-1:0]       scan_rdata,
  output logic                    scan_ready,
  output logic                    scan_err,
  output logic [N_TGT-1:0]        tgt_ren,
  output logic [N_TGT-1:0]        tgt_wen,
  output logic [ADDR_W-1:0]       tgt_addr,
  output logic [DATA_W-1:0]       tgt_wdata,
  input  logic [N_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [N_TGT-1:0]        tgt_ready
);

  if (N_TGT < 2 || N_TGT > 16 || TIMEOUT < 2 || SEL_W >= ADDR_W || (2 ** SEL_W) < N_TGT)
  begin : g_param_check
    $error("scan_target_router: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0]       N_TGT_U   = 32'(N_TGT);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{SEL_W{1'b0}}, {(ADDR_W-SEL_W){1'b1}}};

  state_t             state, state_nx;
  logic [SEL_W-1:0]   sel, sel_nx, req_idx;
  logic               is_wr, is_wr_nx, req_mapped;
  logic [N_TGT-1:0]   ren_nx, wen_nx, req_onehot;
  logic [ADDR_W-1:0]  addr_nx;
  logic [DATA_W-1:0]  wdata_nx, rdata_nx, sel_rdata;
  logic               ready_nx, err_nx, sel_ready;

`ifdef SCAN_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  assign req_idx    = scan_addr[ADDR_W-1 -: SEL_W];
  assign req_mapped = 32'(req_idx) < N_TGT_U;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      is_wr      <= 1'b0;
      tgt_ren    <= '0;
      tgt_wen    <= '0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      scan_err   <= 1'b0;
`ifdef SCAN_ROUTER_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      is_wr      <= is_wr_nx;
      tgt_ren    <= ren_nx;
      tgt_wen    <= wen_nx;
      tgt_addr   <= addr_nx;
      tgt_wdata  <= wdata_nx;
      scan_rdata <= rdata_nx;
      scan_ready <= ready_nx;
      scan_err   <= err_nx;
`ifdef SCAN_ROUTER_TIMEOUT_EN
      cnt        <= cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    is_wr_nx   = is_wr;
    ren_nx     = '0;
    wen_nx     = '0;
    addr_nx    = tgt_addr;
    wdata_nx   = tgt_wdata;
    rdata_nx   = '0;
    ready_nx   = 1'b0;
    err_nx     = 1'b0;
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
`ifdef SCAN_ROUTER_TIMEOUT_EN
    cnt_nx     = cnt;
`endif

    // Ready/data of non-selected targets never reach the response path.
    for (int unsigned i = 0; i < N_TGT_U; i++) begin
      req_onehot[i] = (32'(req_idx) == i);
      if (32'(sel) == i) begin
        sel_ready = tgt_ready[i];
        sel_rdata = tgt_rdata[i*DATA_W +: DATA_W];
      end
    end

    case (state)
      IDLE: begin
        if (scan_ren || scan_wen) begin
          if ((scan_ren && scan_wen) || !req_mapped) begin
            ready_nx = 1'b1;
            err_nx   = 1'b1;
            state_nx = RESP;
          end else begin
            sel_nx   = req_idx;
            is_wr_nx = scan_wen;
            addr_nx  = scan_addr & ADDR_MASK;
            wdata_nx = scan_wdata;
            ren_nx   = scan_ren ? req_onehot : '0;
            wen_nx   = scan_wen ? req_onehot : '0;
`ifdef SCAN_ROUTER_TIMEOUT_EN
            cnt_nx   = '0;
`endif
            state_nx = REQ;
          end
        end
      end
      REQ, WAIT: begin
        state_nx = WAIT;
        if (sel_ready) begin
          ready_nx = 1'b1;
          rdata_nx = is_wr ? '0 : sel_rdata;
          state_nx = RESP;
        end
`ifdef SCAN_ROUTER_TIMEOUT_EN
        else if (state == WAIT && cnt == CNT_W'(TIMEOUT-1)) begin
          ready_nx = 1'b1;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/scan_target_router.md
# scan_target_router

Parametrised, registered router between the scan synchroniser/controller and N scan-addressable targets (SRAMs, control/status register banks). The upper address bits select a target. The block issues a single-cycle read/write strobe to that target and waits for its ready. It then returns a registered one-cycle response (data and error flag) to the scan side. It replaces the fixed two-way SRAM/register combinational split and adds unmapped-address and timeout error reporting.

## Interface
Parameters:
- N_TGT, 2: number of targets, 2..16
- ADDR_W, 16: scan address width
- DATA_W, 32: data width
- SEL_W, 1: address MSBs used as target index; 2**SEL_W >= N_TGT
- TIMEOUT, 64: cycles to wait for target ready, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- scan_ren  in  1  read request
- scan_wen  in  1  write request
- scan_addr  in  ADDR_W  address; [ADDR_W-1 -: SEL_W] is the target index
- scan_wdata  in  DATA_W  write data
- scan_rdata  out  DATA_W  read data, valid while scan_ready=1
- scan_ready  out  1  one-cycle response pulse
- scan_err  out  1  error qualifier, valid while scan_ready=1
- tgt_ren  out  N_TGT  per-target read strobe
- tgt_wen  out  N_TGT  per-target write strobe
- tgt_addr  out  ADDR_W  registered address, select bits forced to 0
- tgt_wdata  out  DATA_W  registered write data
- tgt_rdata  in  N_TGT*DATA_W  target i read data at [i*DATA_W +: DATA_W]
- tgt_ready  in  N_TGT  per-target completion

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - Samples scan_ren/scan_wen.
  - Exactly one request high with index < N_TGT: latch index, op, tgt_addr, tgt_wdata; go to REQ.
  - Index >= N_TGT, or both ren and wen high: go to RESP with err=1 and rdata=0. No target strobe is issued.
- **REQ** (1 cycle)
  - Selected bit of tgt_ren or tgt_wen = 1; all other strobe bits 0.
  - Timeout counter cleared.
  - tgt_ready[sel] seen in this cycle: capture data, go to RESP.
  - Otherwise go to WAIT.
- **WAIT**
  - Strobes 0; counter increments each cycle.
  - tgt_ready[sel]=1: on a read, capture tgt_rdata slice; go to RESP with err=0.
  - Counter reaches TIMEOUT-1 with no ready: go to RESP with err=1 and rdata=0.
- **RESP** (1 cycle)
  - scan_ready=1.
  - scan_rdata holds the captured read data; 0 for writes and errors.
  - scan_err as decided above.
  - Next state IDLE.
- tgt_ready from non-selected targets is ignored in every state. tgt_ready in IDLE or RESP is ignored, which covers a late ready after a timeout.
- Requests arriving outside IDLE are dropped. The scan master must hold off until scan_ready.
- Register field slicing is the target's job. The router moves full DATA_W words.

## Timing
- Reset (async assert): state=IDLE, counter=0.
  - Outputs: scan_ready=0, scan_err=0, scan_rdata=0, tgt_ren=0, tgt_wen=0, tgt_addr=0, tgt_wdata=0.
  - Reset mid-transaction aborts it; no response is issued.
- Request sampled at edge T:
  - Strobe is high in cycle T+1.
  - With zero-wait ready (ready in cycle T+1), scan_ready is high in T+2 and the block is in IDLE at T+3.
  - With ready k cycles after the strobe, scan_ready is high in T+2+k.
- Error without a strobe (unmapped index or both requests): scan_ready high in T+1.
- Timeout: REQ plus WAIT last exactly TIMEOUT cycles. scan_ready/err are high in T+1+TIMEOUT.
- All outputs are registered; there are no combinational scan-to-target paths.
- Back-to-back throughput is at best one transaction per 3 cycles.

## Configuration
- SCAN_ROUTER_TIMEOUT_EN
  - Defined: timeout counter and timeout error behave as specified above.
  - Undefined: no counter is built; WAIT persists until tgt_ready[sel] or reset. scan_err is still raised for unmapped or conflicting requests.

## Test plan
- N_TGT=2, write 0xA5A5_0001 to addr 0x8004, target 1 ready same cycle as strobe:
  - tgt_wen=2'b10 for 1 cycle, tgt_addr=0x0004, tgt_wdata=0xA5A5_0001.
  - scan_ready with err=0 two cycles after the request; rdata=0.
- Read addr 0x0010, target 0 ready 3 cycles after strobe with rdata 0x1234_5678:
  - scan_rdata=0x1234_5678, err=0, scan_ready at T+5.
  - tgt_ready[1] pulses during the wait are ignored.
- N_TGT=3, SEL_W=2, read addr 0xC000:
  - No strobe; scan_ready with err=1 and rdata=0 at T+1.
- scan_ren=scan_wen=1:
  - No strobe; err=1 at T+1.
- Macro defined, TIMEOUT=8, target never ready:
  - err=1 and rdata=0 at T+9.
  - A ready asserted at T+12 is ignored; the next request completes normally.
- rst_n pulsed low while in WAIT:
  - All outputs 0 immediately; no scan_ready.
  - A subsequent request completes normally.
